// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS pipeline: machine word, next-PC select and fetch FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_NEXT = 2'b00,
    PC_BR   = 2'b01,
    PC_J    = 2'b10,
    PC_JR   = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    HOLD = 2'b01,
    HALT = 2'b10
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Instruction fetches are always word aligned, whatever the target source supplied.
  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_latch.sv
// IF/ID pipeline register: flush wins over load, otherwise the held instruction stays put.
module fetch_latch
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  en,
  input  logic  flush,
  input  word_t instr_d,
  input  word_t npc_d,
  output word_t if_instr,
  output word_t if_npc,
  output logic  if_valid
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      if_instr <= '0;
      if_npc   <= '0;
      if_valid <= 1'b0;
    end else if (flush) begin
      if_instr <= '0;
      if_npc   <= '0;
      if_valid <= 1'b0;
    end else if (en) begin
      if_instr <= instr_d;
      if_npc   <= npc_d;
      if_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC select, icache request FSM with a one-word hold buffer.
// Define FETCH_PERF_EN to add the fetch_count/stall_count performance counters.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  word_t       imemload,
  input  logic        PCWE,
  input  logic        fetch_EN,
  input  logic        fetch_NOP,
  input  logic [1:0]  PCSrc,
  input  word_t       branch_addr,
  input  word_t       jump_addr,
  input  word_t       jr_addr,
  input  logic        halt,
`ifdef FETCH_PERF_EN
  output word_t       fetch_count,
  output word_t       stall_count,
`endif
  output logic        iREN,
  output word_t       imemaddr,
  output word_t       if_instr,
  output word_t       if_npc,
  output logic        if_valid
);

  fetch_state_t state;
  pcsrc_t       pc_src;
  word_t        pc;
  word_t        pc_plus4;
  word_t        pc_target;
  word_t        buf_instr;
  word_t        buf_npc;
  word_t        latch_instr;
  word_t        latch_npc;
  logic         redirect;
  logic         halting;
  logic         take_ihit;
  logic         take_buf;
  logic         latch_en;
  logic         latch_flush;

  assign pc_src   = pcsrc_t'(PCSrc);
  assign pc_plus4 = pc + PC_STEP;

  always_comb begin
    pc_target = pc_plus4;
    unique case (pc_src)
      PC_NEXT: pc_target = pc_plus4;
      PC_BR:   pc_target = branch_addr;
      PC_J:    pc_target = jump_addr;
      PC_JR:   pc_target = jr_addr;
    endcase
  end

  // A redirect invalidates whatever word is in flight or buffered; halt outranks everything.
  assign redirect    = PCWE && (pc_src != PC_NEXT);
  assign halting     = halt || (state == HALT);
  assign take_ihit   = (state == REQ) && ihit && !redirect && !halting;
  assign take_buf    = (state == HOLD) && fetch_EN && !redirect && !halting;
  assign latch_en    = (take_ihit && fetch_EN) || take_buf;
  assign latch_flush = fetch_NOP || halting;
  assign latch_instr = (state == HOLD) ? buf_instr : imemload;
  assign latch_npc   = (state == HOLD) ? buf_npc : pc_plus4;

  assign iREN     = nRST && (state == REQ);
  assign imemaddr = pc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= REQ;
      pc        <= PC_INIT;
      buf_instr <= '0;
      buf_npc   <= '0;
    end else if (halting) begin
      state <= HALT;
    end else begin
      if (PCWE)
        pc <= align_word(pc_target);
      case (state)
        REQ: begin
          if (take_ihit && !fetch_EN) begin
            buf_instr <= imemload;
            buf_npc   <= pc_plus4;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (redirect || fetch_EN)
            state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_latch u_latch (
    .CLK      (CLK),
    .nRST     (nRST),
    .en       (latch_en),
    .flush    (latch_flush),
    .instr_d  (latch_instr),
    .npc_d    (latch_npc),
    .if_instr (if_instr),
    .if_npc   (if_npc),
    .if_valid (if_valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (latch_en && !latch_flush)
        fetch_count <= fetch_count + 32'd1;
      if (((state == REQ) && !ihit) || (state == HOLD))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: stimulus pushes expected post-edge outputs, a negedge monitor checks them.
module tb_fetch_stage;

  typedef struct {
    int          id;
    logic        iren;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        PCWE;
  logic        fetch_EN;
  logic        fetch_NOP;
  logic [1:0]  PCSrc;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic [31:0] jr_addr;
  logic        halt;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] if_instr;
  logic [31:0] if_npc;
  logic        if_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  localparam logic [31:0] W_A = 32'h2001_0001;
  localparam logic [31:0] W_B = 32'h8C22_0008;
  localparam logic [31:0] W_C = 32'h1111_2222;
  localparam logic [31:0] W_D = 32'hAC23_0004;
  localparam logic [31:0] W_E = 32'h0123_4567;
  localparam logic [31:0] W_F = 32'h0800_0010;
  localparam logic [31:0] W_G = 32'h1234_5678;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .PCWE        (PCWE),
    .fetch_EN    (fetch_EN),
    .fetch_NOP   (fetch_NOP),
    .PCSrc       (PCSrc),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .jr_addr     (jr_addr),
    .halt        (halt),
`ifdef FETCH_PERF_EN
    .fetch_count (fetch_count),
    .stall_count (stall_count),
`endif
    .iREN        (iREN),
    .imemaddr    (imemaddr),
    .if_instr    (if_instr),
    .if_npc      (if_npc),
    .if_valid    (if_valid)
  );

  task automatic checkOutput(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  // Drive one cycle of inputs; the expected outputs after the coming edge go to the scoreboard.
  task automatic applyStimulus(input logic i_hit, input logic [31:0] i_load, input logic i_pcwe,
                               input logic i_en, input logic i_nop, input logic [1:0] i_src,
                               input logic [31:0] i_tgt, input logic i_halt,
                               input logic e_iren, input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_instr, input logic [31:0] e_npc);
    exp_t e;
    ihit        = i_hit;
    imemload    = i_load;
    PCWE        = i_pcwe;
    fetch_EN    = i_en;
    fetch_NOP   = i_nop;
    PCSrc       = i_src;
    halt        = i_halt;
    branch_addr = (i_src == 2'b01) ? i_tgt : 32'hDEAD_0010;
    jump_addr   = (i_src == 2'b10) ? i_tgt : 32'hDEAD_0020;
    jr_addr     = (i_src == 2'b11) ? i_tgt : 32'hDEAD_0030;
    step_id++;
    e.id    = step_id;
    e.iren  = e_iren;
    e.addr  = e_addr;
    e.valid = e_valid;
    e.instr = e_instr;
    e.npc   = e_npc;
    @(posedge CLK);
    sb.push_back(e);
    #1;
  endtask

  task automatic checkReset(input int id);
    checkOutput("rst_iREN", id, {31'd0, iREN}, 32'd0);
    checkOutput("rst_imemaddr", id, imemaddr, 32'd0);
    checkOutput("rst_if_valid", id, {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_instr", id, if_instr, 32'd0);
    checkOutput("rst_if_npc", id, if_npc, 32'd0);
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("iREN", e.id, {31'd0, iREN}, {31'd0, e.iren});
      checkOutput("imemaddr", e.id, imemaddr, e.addr);
      checkOutput("if_valid", e.id, {31'd0, if_valid}, {31'd0, e.valid});
      checkOutput("if_instr", e.id, if_instr, e.instr);
      checkOutput("if_npc", e.id, if_npc, e.npc);
    end
  end

  task automatic drainScoreboard();
    int budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; imemload = '0; PCWE = 1'b0; fetch_EN = 1'b0; fetch_NOP = 1'b0;
    PCSrc = 2'b00; branch_addr = '0; jump_addr = '0; jr_addr = '0; halt = 1'b0;
    #2;
    checkReset(0);
    #6;
    nRST = 1'b1;
    #1;
    checkOutput("iREN_after_reset", 0, {31'd0, iREN}, 32'd1);

    // Straight-line fetch, then a stalled latch forcing the hold buffer
    applyStimulus(1, W_A, 1, 1, 0, 2'b00, 0, 0,   1, 32'h4, 1, W_A, 32'h4);
    applyStimulus(1, W_A, 1, 1, 0, 2'b00, 0, 0,   1, 32'h8, 1, W_A, 32'h8);
    applyStimulus(1, W_B, 0, 0, 0, 2'b00, 0, 0,   0, 32'h8, 1, W_A, 32'h8);
    applyStimulus(0, W_B, 0, 0, 0, 2'b00, 0, 0,   0, 32'h8, 1, W_A, 32'h8);
    applyStimulus(0, W_B, 1, 1, 0, 2'b00, 0, 0,   1, 32'hC, 1, W_B, 32'hC);

    // Branch with flush: same-cycle ihit word dropped
    applyStimulus(1, W_C, 1, 1, 1, 2'b01, 32'h40, 0,   1, 32'h40, 0, 32'h0, 32'h0);
    applyStimulus(1, W_D, 1, 1, 0, 2'b00, 0, 0,        1, 32'h44, 1, W_D, 32'h44);

    // Hold buffer discarded by a JR redirect to an unaligned target
    applyStimulus(1, W_E, 0, 0, 0, 2'b00, 0, 0,        0, 32'h44, 1, W_D, 32'h44);
    applyStimulus(0, W_E, 1, 0, 0, 2'b11, 32'h103, 0,  1, 32'h100, 1, W_D, 32'h44);
    applyStimulus(0, W_E, 0, 1, 0, 2'b00, 0, 0,        1, 32'h100, 1, W_D, 32'h44);
    applyStimulus(1, W_F, 1, 1, 0, 2'b00, 0, 0,        1, 32'h104, 1, W_F, 32'h104);

    // Halt beats a jump and is sticky
    applyStimulus(1, W_F, 1, 1, 0, 2'b10, 32'h200, 1,  0, 32'h104, 0, 32'h0, 32'h0);
    applyStimulus(1, W_F, 1, 1, 0, 2'b00, 0, 0,        0, 32'h104, 0, 32'h0, 32'h0);
    applyStimulus(1, W_F, 1, 1, 0, 2'b10, 32'h200, 0,  0, 32'h104, 0, 32'h0, 32'h0);
    drainScoreboard();

    nRST = 1'b0;
    #1;
    checkReset(100);
    #1;
    nRST = 1'b1;

    // PC wrap at the top of the address space
    applyStimulus(0, W_G, 1, 1, 0, 2'b10, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
    applyStimulus(1, W_G, 1, 1, 0, 2'b00, 0, 0,        1, 32'h0, 1, W_G, 32'h0);
    applyStimulus(0, W_G, 0, 1, 0, 2'b00, 0, 0,        1, 32'h0, 1, W_G, 32'h0);
    drainScoreboard();

    // Asynchronous reset mid-request, between clock edges
    #1;
    nRST = 1'b0;
    #1;
    checkReset(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
